// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: arbiter and sequencer for the single shared SISC memory port.
// Fetch and data requesters share one port. Data has strict priority over fetch.
// Each access takes one ISSUE cycle. A read then spends RD_LAT cycles in WAIT
// before its data is returned to the requester that owns it.
// Optional feature macro: SISC_ARB_FAIR_EN. It adds a starvation counter that
// forces a fetch grant after STARVE_MAX back-to-back data grants.
module sisc_mem_arb #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_f,
    // fetch requester
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data requester
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Reject out-of-range configurations at elaboration time
    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
        $error("sisc_mem_arb: RD_LAT must be in 1..8");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("sisc_mem_arb: STARVE_MAX must be in 1..15");
    end

    localparam logic [3:0] LatInit = 4'(RD_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;        // 1 = data requester, 0 = fetch
    logic [3:0]    lat_cnt_q, lat_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          pick_data;

`ifdef SISC_ARB_FAIR_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       fetch_forced;

    // Fetch has waited through STARVE_MAX data grants, so it wins this round
    assign fetch_forced = if_req && (starve_q == StarveMax);
    assign pick_data    = d_req && !fetch_forced;

    // Count data grants issued while fetch waits; clear once fetch is served or idle
    always_comb begin
        starve_d = starve_q;
        if (state_q == StIdle && !if_req) begin
            starve_d = 4'd0;
        end else if (state_q == StIssue) begin
            if (!owner_q) begin
                starve_d = 4'd0;
            end else if (if_req && starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign pick_data = d_req;
`endif

    // Sequencer next state: arbitrate in IDLE, strobe in ISSUE, count out read latency in WAIT
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    state_d = StIssue;
                    owner_d = pick_data;
                    if (pick_data) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_we_d    = d_we;
                    end else begin
                        // Fetch carries no write data; mem_wdata keeps its last value
                        mem_addr_d = if_addr;
                        mem_we_d   = 1'b0;
                    end
                end
            end
            StIssue: begin
                if (mem_we_q) begin
                    state_d = StIdle;
                end else begin
                    state_d   = StWait;
                    lat_cnt_d = LatInit;
                end
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d   = StIdle;
                    lat_cnt_d = 4'd0;
                    if (owner_q) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any read in flight
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            lat_cnt_q   <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Port strobes and grants are decoded from state so they drop as soon as reset asserts
    always_comb begin
        mem_en    = (state_q == StIssue);
        if_gnt    = mem_en && !owner_q;
        d_gnt     = mem_en && owner_q;
        busy      = (state_q != StIdle);
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if_rvalid = if_rvalid_q;
        if_rdata  = if_rdata_q;
        d_rvalid  = d_rvalid_q;
        d_rdata   = d_rdata_q;
    end

endmodule
